// File: rtl/scene_prop_store_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : scene_prop_store_if
// Purpose  : Instruction handshake and read-port bundle between the
//            instruction decoder / renderer and the scene property store.
// Revision : 1.0 - initial release
// ============================================================================
interface scene_prop_store_if #(
   parameter int DATA_W = 16
);
   logic              inst_valid_in;
   logic              inst_ready_out;
   logic [2:0]        inst_type_in;
   logic [5:0]        l_index_in;
   logic [18:0]       s_index_in;
   logic [4:0]        s_type_in;
   logic [4:0]        prop_in;
   logic [DATA_W-1:0] data_in;
   logic [4:0]        prop2_in;
   logic [DATA_W-1:0] data2_in;
   logic [1:0]        rd_sel_in;
   logic [18:0]       rd_index_in;
   logic [4:0]        rd_prop_in;
   logic [DATA_W-1:0] rd_data_out;
   logic              render_out;
   logic              frame_out;
   logic              err_out;

   // Store side
   modport slave (
      input  inst_valid_in, inst_type_in, l_index_in, s_index_in, s_type_in,
      input  prop_in, data_in, prop2_in, data2_in,
      input  rd_sel_in, rd_index_in, rd_prop_in,
      output inst_ready_out, rd_data_out, render_out, frame_out, err_out
   );

   // Decoder / renderer side
   modport master (
      output inst_valid_in, inst_type_in, l_index_in, s_index_in, s_type_in,
      output prop_in, data_in, prop2_in, data2_in,
      output rd_sel_in, rd_index_in, rd_prop_in,
      input  inst_ready_out, rd_data_out, render_out, frame_out, err_out
   );
endinterface
`default_nettype wire

// File: rtl/scene_prop_store.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : scene_prop_store
// Purpose  : Camera / light / shape property tables of DATA_W words, written
//            by decoded instructions and read by the renderer.
//            Optional macro SCENE_DOUBLE_BUFFER_EN: two banks with an
//            IDLE/COPY state machine; writes hit the shadow bank, reads see
//            the active bank, opFrame swaps and then re-syncs the shadow.
//            Without it: one bank, ready tied high.
// Revision : 1.0 - initial release
// ============================================================================
module scene_prop_store #(
   parameter int NUM_LIGHTS = 8,
   parameter int NUM_SHAPES = 16,
   parameter int NUM_PROPS  = 16,
   parameter int DATA_W     = 16
) (
   input  logic               clk_in,
   input  logic               rst_n_in,
   scene_prop_store_if.slave  bus
);

   // Flat word layout: entry 0 camera, then lights, then shapes.
   localparam int NUM_ENTRIES = 1 + NUM_LIGHTS + NUM_SHAPES;
   localparam int TOTAL       = NUM_ENTRIES * NUM_PROPS;
   localparam int ADDR_W      = $clog2(TOTAL);
   localparam int LIGHT_BASE  = 1;
   localparam int SHAPE_BASE  = 1 + NUM_LIGHTS;

   localparam logic [2:0] OP_UNSUPPORTED = 3'd0;
   localparam logic [2:0] OP_CAMERA_SET  = 3'd1;
   localparam logic [2:0] OP_LIGHT_SET   = 3'd2;
   localparam logic [2:0] OP_SHAPE_INIT  = 3'd3;
   localparam logic [2:0] OP_SHAPE_SET   = 3'd4;
   localparam logic [2:0] OP_RENDER      = 3'd5;
   localparam logic [2:0] OP_FRAME       = 3'd6;
   localparam logic [2:0] OP_SHAPE_DATA  = 3'd7;

   logic              ready;
   logic              accept;
   int                dec_entry;
   logic              dec_idx_ok;
   logic              dec_set;
   logic              dec_init;
   logic              render_d, frame_d, err_d;
   logic              render_q, frame_q, err_q;
   logic              we1_d, we2_d;
   logic [ADDR_W-1:0] waddr1_d, waddr2_d;
   logic [DATA_W-1:0] wdata1_d, wdata2_d;
   logic              rd_ok;
   logic [ADDR_W-1:0] rd_addr;
   int                rd_entry;
   logic [DATA_W-1:0] rd_data_q;

   // Instruction class, target entry and index range check
   always_comb begin
      accept     = bus.inst_valid_in && ready;
      dec_entry  = 0;
      dec_idx_ok = 1'b0;
      dec_set    = 1'b0;
      dec_init   = 1'b0;
      render_d   = 1'b0;
      frame_d    = 1'b0;
      case (bus.inst_type_in)
         OP_CAMERA_SET: begin
            dec_set    = 1'b1;
            dec_idx_ok = 1'b1;
         end
         OP_LIGHT_SET: begin
            dec_set    = 1'b1;
            dec_idx_ok = int'(bus.l_index_in) < NUM_LIGHTS;
            dec_entry  = LIGHT_BASE + int'(bus.l_index_in);
         end
         OP_SHAPE_SET: begin
            dec_set    = 1'b1;
            dec_idx_ok = int'(bus.s_index_in) < NUM_SHAPES;
            dec_entry  = SHAPE_BASE + int'(bus.s_index_in);
         end
         OP_SHAPE_INIT: begin
            dec_init   = 1'b1;
            dec_idx_ok = int'(bus.s_index_in) < NUM_SHAPES;
            dec_entry  = SHAPE_BASE + int'(bus.s_index_in);
         end
         OP_RENDER:      render_d = accept;
         OP_FRAME:       frame_d  = accept;
         OP_UNSUPPORTED,
         OP_SHAPE_DATA:  ;
         default:        ;
      endcase
   end

   // Word write enables; a bad index drops everything, a bad slot only its word
   always_comb begin
      we1_d    = 1'b0;
      we2_d    = 1'b0;
      waddr1_d = '0;
      waddr2_d = '0;
      wdata1_d = bus.data_in;
      wdata2_d = bus.data2_in;
      err_d    = 1'b0;
      if (accept && (dec_set || dec_init)) begin
         if (!dec_idx_ok) begin
            err_d = 1'b1;
         end else if (dec_init) begin
            we1_d    = 1'b1;
            waddr1_d = ADDR_W'(dec_entry * NUM_PROPS);
            wdata1_d = {{(DATA_W-5){1'b0}}, bus.s_type_in};
         end else begin
            if (int'(bus.prop_in) < NUM_PROPS) begin
               we1_d    = 1'b1;
               waddr1_d = ADDR_W'(dec_entry * NUM_PROPS + int'(bus.prop_in));
            end else begin
               err_d = 1'b1;
            end
            if (bus.prop2_in != bus.prop_in) begin
               if (int'(bus.prop2_in) < NUM_PROPS) begin
                  we2_d    = 1'b1;
                  waddr2_d = ADDR_W'(dec_entry * NUM_PROPS + int'(bus.prop2_in));
               end else begin
                  err_d = 1'b1;
               end
            end
         end
      end
   end

   // Read address decode; out-of-range or sel 3 reads return zero
   always_comb begin
      rd_ok    = 1'b0;
      rd_entry = 0;
      case (bus.rd_sel_in)
         2'd0: rd_ok = 1'b1;
         2'd1: begin
            rd_ok    = int'(bus.rd_index_in) < NUM_LIGHTS;
            rd_entry = LIGHT_BASE + int'(bus.rd_index_in);
         end
         2'd2: begin
            rd_ok    = int'(bus.rd_index_in) < NUM_SHAPES;
            rd_entry = SHAPE_BASE + int'(bus.rd_index_in);
         end
         default: rd_ok = 1'b0;
      endcase
      if (int'(bus.rd_prop_in) >= NUM_PROPS) begin
         rd_ok = 1'b0;
      end
      rd_addr = rd_ok ? ADDR_W'(rd_entry * NUM_PROPS + int'(bus.rd_prop_in)) : '0;
   end

`ifdef SCENE_DOUBLE_BUFFER_EN
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_COPY = 1'b1
   } state_t;

   state_t            state_q;
   logic              active_q;
   logic              ready_q;
   logic [ADDR_W-1:0] cnt_q;
   logic              rd_bank;
   logic [DATA_W-1:0] mem_q [0:1][0:TOTAL-1];

   // A read issued in the swap cycle already targets the new active bank
   assign rd_bank = active_q ^ frame_d;
   assign ready   = ready_q;

   // Bank swap and shadow re-sync sequencer
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q  <= ST_IDLE;
         active_q <= 1'b0;
         ready_q  <= 1'b1;
         cnt_q    <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (frame_d) begin
                  state_q  <= ST_COPY;
                  active_q <= ~active_q;
                  ready_q  <= 1'b0;
                  cnt_q    <= '0;
               end
            end
            ST_COPY: begin
               if (cnt_q == ADDR_W'(TOTAL - 1)) begin
                  state_q <= ST_IDLE;
                  ready_q <= 1'b1;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   // Storage: instruction writes to shadow in IDLE, word-by-word copy in COPY
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < TOTAL; i++) begin
               mem_q[b][i] <= '0;
            end
         end
      end else if (state_q == ST_COPY) begin
         mem_q[~active_q][cnt_q] <= mem_q[active_q][cnt_q];
      end else begin
         if (we1_d) mem_q[~active_q][waddr1_d] <= wdata1_d;
         if (we2_d) mem_q[~active_q][waddr2_d] <= wdata2_d;
      end
   end

   // Registered read port on the active bank
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_ok ? mem_q[rd_bank][rd_addr] : '0;
      end
   end
`else
   logic [DATA_W-1:0] mem_q [0:TOTAL-1];

   assign ready = 1'b1;

   // Single bank storage, written directly by instructions
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int i = 0; i < TOTAL; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (we1_d) mem_q[waddr1_d] <= wdata1_d;
         if (we2_d) mem_q[waddr2_d] <= wdata2_d;
      end
   end

   // Registered read port
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_ok ? mem_q[rd_addr] : '0;
      end
   end
`endif

   // Single-cycle event pulses
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         render_q <= 1'b0;
         frame_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         render_q <= render_d;
         frame_q  <= frame_d;
         err_q    <= err_d;
      end
   end

   assign bus.inst_ready_out = ready;
   assign bus.rd_data_out    = rd_data_q;
   assign bus.render_out     = render_q;
   assign bus.frame_out      = frame_q;
   assign bus.err_out        = err_q;

endmodule
`default_nettype wire
